// File: rtl/slave_responder_if.sv
// Crossbar slave-port bundle for slave_responder.
// The err signal exists only when SLAVE_RESP_ERR_EN is defined.
interface slave_responder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req;
  logic              cmd;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic              resp;
  logic [31:0]       rdata;
  logic              busy;
`ifdef SLAVE_RESP_ERR_EN
  logic              err;

  modport master (output req, cmd, addr, wdata, input ack, resp, rdata, busy, err);
  modport slave  (input req, cmd, addr, wdata, output ack, resp, rdata, busy, err);
`else
  modport master (output req, cmd, addr, wdata, input ack, resp, rdata, busy);
  modport slave  (input req, cmd, addr, wdata, output ack, resp, rdata, busy);
`endif
endinterface

// File: rtl/slave_responder.sv
// Slave-end endpoint: one request at a time against a word memory, fixed-latency resp.
// Optional SLAVE_RESP_ERR_EN: out-of-range addresses are flagged on err instead of aliasing.
module slave_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  slave_responder_if.slave    bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              cmd_q, cmd_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ack_q, ack_d;
  logic              resp_q, resp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_we;
  logic [IDX_W-1:0]  req_idx;
  logic              acc_ok;
  logic              lat_ok;

  logic [31:0]       mem [DEPTH];

  // Modulo keeps every address bit in the index path; for power-of-two DEPTH it is a bit select.
  assign req_idx = IDX_W'({1'b0, bus.addr} % (ADDR_W+1)'(DEPTH));

`ifdef SLAVE_RESP_ERR_EN
  logic oor_q, oor_d;
  logic err_q, err_d;

  assign acc_ok  = ({1'b0, bus.addr} < (ADDR_W+1)'(DEPTH));
  assign lat_ok  = ~oor_q;
  assign bus.err = err_q;
`else
  assign acc_ok = 1'b1;
  assign lat_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    ack_d   = 1'b0;
    resp_d  = 1'b0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
`ifdef SLAVE_RESP_ERR_EN
    oor_d   = oor_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY);
          cmd_d   = bus.cmd;
          idx_d   = req_idx;
          ack_d   = 1'b1;
          mem_we  = bus.cmd & acc_ok;
`ifdef SLAVE_RESP_ERR_EN
          oor_d   = ~acc_ok;
`endif
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          resp_d  = 1'b1;
          if (!cmd_q && lat_ok) rdata_d = mem[idx_q];
`ifdef SLAVE_RESP_ERR_EN
          err_d   = oor_q;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= 1'b0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
`ifdef SLAVE_RESP_ERR_EN
      oor_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
`ifdef SLAVE_RESP_ERR_EN
      oor_q   <= oor_d;
      err_q   <= err_d;
`endif
    end
  end

  // Memory is deliberately outside the reset domain; writes commit at acceptance.
  always_ff @(posedge clk) begin
    if (mem_we) mem[req_idx] <= bus.wdata;
  end

  assign bus.ack   = ack_q;
  assign bus.resp  = resp_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q == WAIT);

endmodule

// File: tb/tb_slave_responder.sv
// Bench for slave_responder: vector table, hand sequences and a random run against a memory model.
`timescale 1ns/1ps
module tb_slave_responder;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned L     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slave_responder_if #(.ADDR_W(AW)) bus ();

  slave_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] rd_last = '0;

  typedef struct {
    bit          c;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: writes land at acceptance, reads return the stored word, rdata otherwise holds.
  task automatic model_step(input bit c, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] exp);
    bit ok;
    ok = 1'b1;
`ifdef SLAVE_RESP_ERR_EN
    ok = (a < DEPTH);
`endif
    exp = rd_last;
    if (ok && c)  mem_m[a % DEPTH] = d;
    if (ok && !c) exp = mem_m[a % DEPTH];
  endtask

  task automatic txn(input bit c, input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd);
    int n;
    bus.req = 1'b1; bus.cmd = c; bus.addr = a; bus.wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.ack !== 1'b1 && n < 20);
    bus.req = 1'b0;
    chk("ack", 32'(bus.ack), 32'd1);
    chk("busy_at_ack", 32'(bus.busy), 32'd1);
    chk("resp_at_ack", 32'(bus.resp), 32'd0);
    for (int k = 1; k < int'(L); k++) begin
      @(negedge clk);
      chk("ack_in_wait", 32'(bus.ack), 32'd0);
      chk("resp_in_wait", 32'(bus.resp), 32'd0);
    end
    @(negedge clk);
    chk("resp", 32'(bus.resp), 32'd1);
    chk("ack_at_resp", 32'(bus.ack), 32'd0);
    chk("busy_at_resp", 32'(bus.busy), 32'd0);
    chk("rdata", bus.rdata, exp_rd);
`ifdef SLAVE_RESP_ERR_EN
    chk("err", 32'(bus.err), 32'(a >= DEPTH));
`endif
    rd_last = exp_rd;
  endtask

  task automatic abort_txn(input bit c, input logic [7:0] a, input logic [31:0] d);
    int n;
    bus.req = 1'b1; bus.cmd = c; bus.addr = a; bus.wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.ack !== 1'b1 && n < 20);
    bus.req = 1'b0;
    chk("abort_ack", 32'(bus.ack), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("busy_in_rst", 32'(bus.busy), 32'd0);
    chk("rdata_in_rst", bus.rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < int'(L) + 3; k++) begin
      @(negedge clk);
      chk("resp_after_rst", 32'(bus.resp), 32'd0);
      chk("busy_after_rst", 32'(bus.busy), 32'd0);
    end
    rd_last = '0;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] e;
    logic [31:0] d;
    logic [7:0]  a;
    bit          c;

    bus.req = 1'b0; bus.cmd = 1'b0; bus.addr = '0; bus.wdata = '0;

    // Reset held for three cycles, then quiet bus.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_resp", 32'(bus.resp), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
`ifdef SLAVE_RESP_ERR_EN
      chk("rst_err", 32'(bus.err), 32'd0);
`endif
    end

    vecs.push_back('{1'b1, 8'd5, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{1'b0, 8'd5, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b1, 8'd3, 32'h00001234, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 8'd3, 32'h0,        32'h00001234});
    vecs.push_back('{1'b1, 8'd3, 32'h0,        32'h00001234});
    vecs.push_back('{1'b0, 8'd3, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 8'd6, 32'h66666666, 32'h0});
    vecs.push_back('{1'b0, 8'd5, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, 8'd6, 32'h0,        32'h66666666});
    foreach (vecs[i]) begin
      model_step(vecs[i].c, vecs[i].a, vecs[i].d, e);
      txn(vecs[i].c, vecs[i].a, vecs[i].d, vecs[i].exp_rd);
    end

    // req held through WAIT: one acceptance every L+1 cycles, ack and resp never together.
    bus.req = 1'b1; bus.cmd = 1'b0; bus.addr = 8'd5;
    for (int k = 0; k < 3 * (int'(L) + 1); k++) begin
      @(negedge clk);
      chk("ack_b2b", 32'(bus.ack), 32'(k % (int'(L) + 1) == 0));
      chk("resp_b2b", 32'(bus.resp), 32'(k % (int'(L) + 1) == int'(L)));
      if (bus.resp) chk("rdata_b2b", bus.rdata, 32'hDEADBEEF);
    end
    bus.req = 1'b0;
    rd_last = 32'hDEADBEEF;

    // Address 70 is 6 modulo DEPTH: aliases by default, rejected with err when the feature is on.
    model_step(1'b1, 8'd70, 32'hFFFFFFFF, e);
    txn(1'b1, 8'd70, 32'hFFFFFFFF, 32'hDEADBEEF);
    model_step(1'b0, 8'd6, 32'h0, e);
`ifdef SLAVE_RESP_ERR_EN
    txn(1'b0, 8'd6, 32'h0, 32'h66666666);
    txn(1'b0, 8'd70, 32'h0, 32'h66666666);
`else
    txn(1'b0, 8'd6, 32'h0, 32'hFFFFFFFF);
`endif

    // Reset during WAIT: no resp, committed write survives.
    model_step(1'b1, 8'd7, 32'h77777777, e);
    abort_txn(1'b1, 8'd7, 32'h77777777);
    abort_txn(1'b0, 8'd3, 32'h0);
    model_step(1'b0, 8'd7, 32'h0, e);
    txn(1'b0, 8'd7, 32'h0, 32'h77777777);

    // Random phase: fill every word, then mixed traffic over the full address range.
    for (int i = 0; i < int'(DEPTH); i++) begin
      d = $urandom;
      model_step(1'b1, 8'(i), d, e);
      txn(1'b1, 8'(i), d, e);
    end
    for (int i = 0; i < 150; i++) begin
      c = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 255));
      d = $urandom;
      model_step(c, a, d, e);
      txn(c, a, d, e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
